// File: rtl/mx_pkg.sv
// Shared types and constants for the MX dot-product sequencer: FSM states, E8M0 constants, width helpers.
// No logic; imported by mx_dot_seq.
package mx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    localparam int         SCALE_BIAS = 127;
    localparam logic [7:0] SCALE_NAN  = 8'hFF;

    // Exact fixed-point width of a k-element FP8 dot product, including sign.
    function automatic int out_width_f(input int exp_w, input int man_w, input int kk);
        return 2 * ((1 << exp_w) + man_w) + $clog2(kk);
    endfunction

    function automatic int acc_width_f(input int out_w, input int max_b);
        return out_w + $clog2(max_b);
    endfunction

endpackage

// File: rtl/mx_dot_seq_dot_fp8.sv
// Combinational k-element FP8 dot product, summed exactly in units of the smallest representable product.
// Zero latency, no handshake: the caller registers the result.
// NaN is the all-ones exponent/mantissa code (OCP E4M3 style); there are no infinities.
module dot_fp8 #(
    parameter int exp_width = 4,
    parameter int man_width = 3,
    parameter int k         = 32,
    parameter int out_width = 2 * ((1 << exp_width) + man_width) + $clog2(k)
) (
    input  logic [k*(1+exp_width+man_width)-1:0] i_vec_a,
    input  logic [k*(1+exp_width+man_width)-1:0] i_vec_b,
    output logic signed [out_width-1:0]          o_dp,
    output logic                                 o_nan
);

    localparam int ew = 1 + exp_width + man_width;
    localparam int fw = man_width + (1 << exp_width) - 1;

    // Magnitude as an integer multiple of the subnormal LSB; exponent 0 is treated as 1 with no hidden bit.
    function automatic logic [fw-1:0] to_fix(input logic [ew-2:0] x);
        logic [exp_width-1:0] e;
        logic [fw-1:0]        sig;
        e   = x[ew-2 -: exp_width];
        sig = fw'({(e != '0), x[man_width-1:0]});
        return (e == '0) ? sig : (sig << (e - 1'b1));
    endfunction

    logic signed [out_width-1:0] prod [k];
    logic [k-1:0]                nan_v;

    for (genvar i = 0; i < k; i++) begin : g_el
        logic [ew-1:0]   a;
        logic [ew-1:0]   b;
        logic [2*fw-1:0] mag;
        assign a        = i_vec_a[i*ew +: ew];
        assign b        = i_vec_b[i*ew +: ew];
        assign mag      = (2*fw)'(to_fix(a[ew-2:0])) * (2*fw)'(to_fix(b[ew-2:0]));
        assign prod[i]  = (a[ew-1] ^ b[ew-1]) ? -$signed(out_width'(mag)) : $signed(out_width'(mag));
        assign nan_v[i] = (&a[ew-2:0]) | (&b[ew-2:0]);
    end

    always_comb begin
        o_dp = '0;
        for (int i = 0; i < k; i++) begin
            o_dp = o_dp + prod[i];
        end
    end

    assign o_nan = |nan_v;

endmodule

// File: rtl/mx_dot_seq.sv
// Sequences one MX dot-product job over up to max_blocks k-element blocks through one dot_fp8.
// Latency: result valid two cycles after the last accepted block; sustains one block per cycle.
// Backpressure: o_ready only in LOAD; result held in DONE until i_ready. Optional MX_DOT_SEQ_STATS_EN adds o_stall_cnt.
module mx_dot_seq
    import mx_pkg::*;
#(
    parameter int exp_width  = 4,
    parameter int man_width  = 3,
    parameter int k          = 32,
    parameter int max_blocks = 16,
    localparam int out_width = out_width_f(exp_width, man_width, k),
    localparam int len_width = $clog2(max_blocks + 1),
    localparam int acc_width = acc_width_f(out_width, max_blocks),
    localparam int el_width  = 1 + exp_width + man_width
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_start,
    input  logic [len_width-1:0]        i_len,
    input  logic [7:0]                  i_scale_a,
    input  logic [7:0]                  i_scale_b,
    output logic                        o_busy,
    input  logic [k*el_width-1:0]       i_vec_a,
    input  logic [k*el_width-1:0]       i_vec_b,
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [acc_width-1:0] o_dp,
    output logic signed [9:0]           o_scale,
    output logic                        o_nan,
    output logic                        o_valid,
    input  logic                        i_ready
`ifdef MX_DOT_SEQ_STATS_EN
    ,
    output logic [15:0]                 o_stall_cnt
`endif
);

    state_t                      state;
    state_t                      state_nx;
    logic [len_width-1:0]        len_q;
    logic [len_width-1:0]        cnt_q;
    logic signed [9:0]           scale_q;
    logic signed [acc_width-1:0] acc_q;
    logic                        nan_q;
    logic                        p1_valid;
    logic signed [out_width-1:0] p1_dp;
    logic                        p1_nan;
    logic signed [out_width-1:0] dot_dp;
    logic                        dot_nan;
    logic                        start_acc;
    logic                        beat_acc;
    logic [len_width-1:0]        len_clamped;

    dot_fp8 #(
        .exp_width (exp_width),
        .man_width (man_width),
        .k         (k),
        .out_width (out_width)
    ) u_dot (
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .o_dp    (dot_dp),
        .o_nan   (dot_nan)
    );

    assign start_acc   = (state == IDLE) && i_start;
    assign beat_acc    = (state == LOAD) && i_valid;
    assign len_clamped = (i_len > len_width'(max_blocks)) ? len_width'(max_blocks) : i_len;

    always_comb begin
        state_nx = state;
        o_ready  = 1'b0;
        o_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nx = (i_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                o_ready = 1'b1;
                if (i_valid && (cnt_q + 1'b1 == len_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                state_nx = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            scale_q  <= '0;
            acc_q    <= '0;
            nan_q    <= 1'b0;
            p1_valid <= 1'b0;
            p1_dp    <= '0;
            p1_nan   <= 1'b0;
        end else begin
            state    <= state_nx;
            p1_valid <= 1'b0;
            if (start_acc) begin
                len_q   <= len_clamped;
                cnt_q   <= '0;
                acc_q   <= '0;
                nan_q   <= (i_scale_a == SCALE_NAN) || (i_scale_b == SCALE_NAN);
                scale_q <= $signed({2'b00, i_scale_a}) + $signed({2'b00, i_scale_b})
                           - $signed(10'(2 * SCALE_BIAS));
            end else if (p1_valid) begin
                // Stage 2: fold the registered partial into the running sum.
                acc_q <= acc_q + {{(acc_width - out_width){p1_dp[out_width-1]}}, p1_dp};
                nan_q <= nan_q | p1_nan;
            end
            if (beat_acc) begin
                p1_valid <= 1'b1;
                p1_dp    <= dot_dp;
                p1_nan   <= dot_nan;
                cnt_q    <= cnt_q + 1'b1;
            end
        end
    end

    assign o_busy  = (state != IDLE);
    assign o_dp    = acc_q;
    assign o_scale = scale_q;
    assign o_nan   = nan_q;

`ifdef MX_DOT_SEQ_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_q <= '0;
        end else if (start_acc) begin
            stall_q <= '0;
        end else if ((state == LOAD) && !i_valid && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign o_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mx_dot_seq.sv
// Self-checking bench for mx_dot_seq: directed corner jobs plus randomized jobs against a value-level FP8 model.
module tb_mx_dot_seq;
    import mx_pkg::*;

    localparam int K    = 32;
    localparam int MAXB = 16;
    localparam int LENW = $clog2(MAXB + 1);
    localparam int ACCW = acc_width_f(out_width_f(4, 3, K), MAXB);
    localparam int VW   = K * 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic [LENW-1:0]        len_in;
    logic [7:0]             sc_a;
    logic [7:0]             sc_b;
    logic                   busy;
    logic [VW-1:0]          vec_a;
    logic [VW-1:0]          vec_b;
    logic                   valid;
    logic                   ready;
    logic signed [ACCW-1:0] dp;
    logic signed [9:0]      scale;
    logic                   nan;
    logic                   ovalid;
    logic                   iready;
`ifdef MX_DOT_SEQ_STATS_EN
    logic [15:0]            stall_cnt;
`endif

    mx_dot_seq dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_len     (len_in),
        .i_scale_a (sc_a),
        .i_scale_b (sc_b),
        .o_busy    (busy),
        .i_vec_a   (vec_a),
        .i_vec_b   (vec_b),
        .i_valid   (valid),
        .o_ready   (ready),
        .o_dp      (dp),
        .o_scale   (scale),
        .o_nan     (nan),
        .o_valid   (ovalid),
        .i_ready   (iready)
`ifdef MX_DOT_SEQ_STATS_EN
        ,
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] ja [MAXB];
    logic [VW-1:0] jb [MAXB];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Element value in units of 2^-9, the E4M3 subnormal step.
    function automatic longint elem_units(input logic [7:0] x);
        int     e = int'(x[6:3]);
        int     m = int'(x[2:0]);
        longint v;
        if (e == 0) v = m;
        else        v = longint'(8 + m) * (longint'(1) << (e - 1));
        return x[7] ? -v : v;
    endfunction

    function automatic bit elem_nan(input logic [7:0] x);
        return x[6:0] == 7'h7F;
    endfunction

    task automatic fill_const(input int b, input logic [7:0] ea, input logic [7:0] eb);
        for (int i = 0; i < K; i++) begin
            ja[b][i*8 +: 8] = ea;
            jb[b][i*8 +: 8] = eb;
        end
    endtask

    task automatic fill_rand(input int b);
        logic [7:0] x;
        for (int i = 0; i < K; i++) begin
            x = 8'($urandom);
            if (x[6:0] == 7'h7F) x[0] = 1'b0;
            ja[b][i*8 +: 8] = x;
            x = 8'($urandom);
            if (x[6:0] == 7'h7F) x[0] = 1'b0;
            jb[b][i*8 +: 8] = x;
        end
    endtask

    task automatic run_job(input string name, input int len, input int sa, input int sb,
                           input int gap, input int hold,
                           output longint got_dp, output int got_scale, output bit got_nan);
        int     nblk;
        int     t;
        longint exp_dp;
        bit     exp_nan;
        logic [7:0] ea, eb;
        logic signed [ACCW-1:0] held_dp;

        nblk    = (len > MAXB) ? MAXB : len;
        exp_dp  = 0;
        exp_nan = (sa == 255) || (sb == 255);
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < K; i++) begin
                ea = ja[b][i*8 +: 8];
                eb = jb[b][i*8 +: 8];
                exp_dp  += elem_units(ea) * elem_units(eb);
                exp_nan |= elem_nan(ea) | elem_nan(eb);
            end
        end

        @(negedge clk);
        start  = 1'b1;
        len_in = LENW'(len);
        sc_a   = 8'(sa);
        sc_b   = 8'(sb);
        @(negedge clk);
        start = 1'b0;
        check({name, ":busy"}, busy, 1);

        for (int b = 0; b < nblk; b++) begin
            if (b > 0) repeat (gap) @(negedge clk);
            vec_a = ja[b];
            vec_b = jb[b];
            valid = 1'b1;
            t = 0;
            while (!ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (t == 20) check({name, ":ready_timeout"}, ready, 1);
            @(negedge clk);
            valid = 1'b0;
        end

        if (nblk > 0) begin
            check({name, ":drain_vld"}, ovalid, 0);
            @(negedge clk);
            check({name, ":lat_vld"}, ovalid, 1);
        end
        t = 0;
        while (!ovalid && t < 2) begin
            @(negedge clk);
            t++;
        end
        check({name, ":vld"}, ovalid, 1);
        check({name, ":dp"}, dp, exp_dp);
        check({name, ":scale"}, scale, sa + sb - 254);
        check({name, ":nan"}, nan, exp_nan);
`ifdef MX_DOT_SEQ_STATS_EN
        check({name, ":stall"}, stall_cnt, (nblk > 0) ? gap * (nblk - 1) : 0);
`endif
        got_dp    = dp;
        got_scale = scale;
        got_nan   = nan;
        held_dp   = dp;

        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                start  = 1'b1;
                len_in = LENW'(3);
            end
            @(negedge clk);
            start = 1'b0;
            check({name, ":hold_vld"}, ovalid, 1);
            check({name, ":hold_dp"}, dp, held_dp);
        end

        iready = 1'b1;
        start  = 1'b1;
        len_in = LENW'(2);
        @(negedge clk);
        iready = 1'b0;
        start  = 1'b0;
        check({name, ":ack_vld"}, ovalid, 0);
        check({name, ":ack_busy"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    longint r_dp;
    int     r_sc;
    bit     r_nan;
    bit     seen;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        len_in = '0;
        sc_a   = '0;
        sc_b   = '0;
        vec_a  = '0;
        vec_b  = '0;
        valid  = 1'b0;
        iready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        check("rst_vld", ovalid, 0);
        check("rst_nan", nan, 0);
        check("rst_dp", dp, 0);
        check("rst_scale", scale, 0);
`ifdef MX_DOT_SEQ_STATS_EN
        check("rst_stall", stall_cnt, 0);
`endif
        rst = 1'b0;

        for (int b = 0; b < 4; b++) fill_const(b, 8'h38, 8'h38);
        run_job("ones4", 4, 127, 127, 0, 0, r_dp, r_sc, r_nan);
        check("ones4_const", r_dp, 4 * 32 * (64'sd1 << 18));
        check("ones4_scale0", r_sc, 0);

        run_job("gap3", 3, 127, 127, 2, 1, r_dp, r_sc, r_nan);
        check("gap3_const", r_dp, 3 * 32 * (64'sd1 << 18));

        fill_rand(0);
        fill_rand(1);
        ja[1][5*8 +: 8] = 8'h7F;
        run_job("nan_elem", 2, 127, 127, 0, 0, r_dp, r_sc, r_nan);
        check("nan_elem_flag", r_nan, 1);

        fill_const(0, 8'h38, 8'h38);
        run_job("nan_scale", 1, 255, 127, 0, 0, r_dp, r_sc, r_nan);
        check("nan_scale_flag", r_nan, 1);

        run_job("scale_m4", 1, 130, 120, 0, 0, r_dp, r_sc, r_nan);
        check("scale_m4_val", r_sc, -4);

        run_job("len0", 0, 127, 127, 0, 5, r_dp, r_sc, r_nan);
        check("len0_dp", r_dp, 0);

        fill_const(0, 8'h38, 8'hB8);
        fill_const(1, 8'h38, 8'h38);
        run_job("mixed", 2, 127, 127, 0, 0, r_dp, r_sc, r_nan);
        check("mixed_zero", r_dp, 0);

        for (int b = 0; b < MAXB; b++) fill_const(b, 8'h7E, 8'hFE);
        run_job("maxmag", MAXB, 127, 127, 0, 0, r_dp, r_sc, r_nan);
        check("maxmag_neg", r_dp, -(longint'(MAXB) * 32 * 229376 * 229376));

        for (int b = 0; b < MAXB; b++) fill_rand(b);
        run_job("clamp", 20, 127, 127, 0, 0, r_dp, r_sc, r_nan);

        for (int b = 0; b < 5; b++) fill_const(b, 8'h40, 8'h40);
        @(negedge clk);
        start  = 1'b1;
        len_in = LENW'(5);
        sc_a   = 8'd127;
        sc_b   = 8'd127;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            vec_a = ja[b];
            vec_b = jb[b];
            valid = 1'b1;
            @(negedge clk);
        end
        valid = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_ready", ready, 0);
        check("midrst_dp", dp, 0);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ovalid) seen = 1'b1;
        end
        check("midrst_novld", seen, 0);
        fill_const(0, 8'h38, 8'h38);
        run_job("after_rst", 1, 127, 127, 0, 0, r_dp, r_sc, r_nan);
        check("after_rst_const", r_dp, 32 * (64'sd1 << 18));

        for (int j = 0; j < 8; j++) begin
            int rl;
            rl = $urandom_range(1, MAXB);
            for (int b = 0; b < rl; b++) fill_rand(b);
            run_job($sformatf("rand%0d", j), rl, $urandom_range(100, 254), $urandom_range(0, 254),
                    $urandom_range(0, 2), $urandom_range(0, 3), r_dp, r_sc, r_nan);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
